alarm_unit_ctrl: RTL
====================

Name: alarm_unit_ctrl

Overview:
- Next-generation alarm block: holds a user-settable alarm time and compares it against the running clock time on each minute boundary.
- Sequences the alarm through arm / ring / snooze / timeout, with runtime 12h/24h display and parametrised snooze and ring durations.
- Fully synchronous to one clock; no derived or ripple clocks.
- Sits beside the timekeeping block and feeds the display mux and the buzzer driver.

Parameters:
- INIT_HOUR, 6, alarm hour after reset (binary, 0..23)
- INIT_MIN, 30, alarm minute after reset (binary, 0..59)
- SNOOZE_MIN, 5, snooze length in minutes (1..15)
- RING_TIMEOUT_MIN, 10, minutes of unattended ringing before auto-stop (1..15)
- CNT_BITS, 4, width of the snooze and ring minute counters; must hold max(SNOOZE_MIN, RING_TIMEOUT_MIN)

Ports:
- clk  in  1  system clock
- reset  in  1  reset; asynchronous, active-low
- set_alarm  in  1  level; alarm edit mode
- min_inc  in  1  one-cycle pulse; increment alarm minute
- hr_inc  in  1  one-cycle pulse; increment alarm hour
- mode_12h  in  1  level; 1 = 12h display, 0 = 24h display
- alarm_en  in  1  level; arms the alarm
- snooze  in  1  one-cycle pulse
- stop  in  1  one-cycle pulse
- minute_tick  in  1  one-cycle pulse issued by timekeeping on each minute change
- cur_hour  in  5  current hour, binary 0..23, valid when minute_tick is high
- cur_min  in  6  current minute, binary 0..59, valid when minute_tick is high
- unit_min, tens_min, unit_hour, tens_hour  out  4 each  alarm time in BCD
- pm  out  1  high when alarm hour >= 12 and mode_12h = 1; otherwise 0
- ringing  out  1  buzzer enable
- state  out  2  0 DISARMED, 1 ARMED, 2 RINGING, 3 SNOOZING

Behaviour:
- Reset (reset = 0, asynchronous): alarm hour/min = INIT_HOUR/INIT_MIN; state = DISARMED; ringing = 0; both counters = 0.
- Alarm time storage: binary registers hour[4:0] and min[5:0].
- Edit: with set_alarm = 1, min_inc steps minute 0..59 and wraps 59 -> 0 with no carry into hour. hr_inc steps hour 0..23 and wraps 23 -> 0.
- min_inc and hr_inc in the same cycle: both apply.
- Increments with set_alarm = 0 are ignored.
- Edit visible on the outputs one edge after the pulse.
- Display: outputs are combinational from the registers.
  - 24h mode: BCD of hour.
  - 12h mode: h12 = 12 if hour mod 12 = 0, else hour mod 12.
  - Example: hour 0 -> "12", pm = 0; hour 13 -> "01", pm = 1.
  - mode_12h changes the display only, never the stored value.
- FSM priority, highest first: alarm_en = 0 > set_alarm = 1 > stop > snooze > minute_tick.
  - Any state, alarm_en = 0: next state DISARMED.
  - DISARMED -> ARMED when alarm_en = 1.
  - ARMED -> RINGING when minute_tick = 1 and cur_hour:cur_min equals the alarm time and set_alarm = 0. ring_cnt cleared on entry.
  - RINGING:
    - set_alarm = 1 or stop -> ARMED.
    - snooze -> SNOOZING, snz_cnt loaded with SNOOZE_MIN.
    - Otherwise, on minute_tick ring_cnt increments; when it reaches RING_TIMEOUT_MIN -> ARMED.
  - SNOOZING:
    - set_alarm = 1 or stop -> ARMED.
    - On minute_tick snz_cnt decrements; when it reaches 0 -> RINGING with ring_cnt cleared.
    - snooze pulses while SNOOZING are ignored.
- ringing = (state == RINGING). Registered state, so ringing asserts on the edge after the matching minute_tick.
- Re-match: after stop or timeout in ARMED, the same time matches again only on the next day's tick. No extra guard is needed because the match is evaluated only on minute_tick.
- Reset mid-ring or mid-snooze: immediate return to the reset values.

Decomposition:
- Shared package holds:
  - state encoding constants ST_DISARMED/ST_ARMED/ST_RINGING/ST_SNOOZING
  - HOURS_PER_DAY = 24, MIN_PER_HOUR = 60
- One sub-module: bcd_split_2digit, a combinational binary 0..59 -> {tens, units} converter. Instantiated twice, for minutes and for the display hour.

Test Plan:
- Reset release -> digits 0,6,3,0 (tens_hour..unit_min); state = 0; ringing = 0.
- set_alarm = 1, 30 min_inc pulses from 06:30 -> 06:00 with hour unchanged. 18 hr_inc pulses -> 00:00. With mode_12h = 1 -> display 12:00, pm = 0.
- alarm_en = 1, alarm 07:15, minute_tick with cur 07:15 -> ringing = 1 one edge later. Then 10 minute_ticks with no input -> state ARMED, ringing = 0.
- While ringing: snooze pulse -> state 3. Four minute_ticks -> still 3. Fifth -> state 2, ringing = 1.
- stop and snooze in the same cycle while RINGING -> state ARMED (stop wins). alarm_en = 0 while SNOOZING -> DISARMED next edge.
- Match tick with set_alarm = 1 -> no ring. Reset asserted while RINGING -> ringing = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alarm_unit_ctrl_pkg.sv
// Shared definitions for the alarm controller: FSM encoding, time constants
// and the 12h display-hour mapping.
package alarm_unit_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZING = 2'd3
    } alarm_state_t;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;

    // Hour as shown on the display; 0 and 12 both read "12" in 12h mode.
    function automatic logic [4:0] display_hour(input logic [4:0] hour, input logic mode_12h);
        logic [4:0] h;
        h = hour;
        if (mode_12h) begin
            if (hour == 5'd0)
                h = 5'd12;
            else if (hour > 5'd12)
                h = hour - 5'd12;
        end
        return h;
    endfunction

endpackage

// File: rtl/alarm_unit_ctrl_bcd_split_2digit.sv
// Combinational binary 0..59 to two BCD digits.
module bcd_split_2digit (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);
    logic [3:0] off;

    always_comb begin
        tens = 4'd0;
        off  = 4'd0;
        if (bin >= 6'd50) begin
            tens = 4'd5;
            off  = 4'd2;
        end else if (bin >= 6'd40) begin
            tens = 4'd4;
            off  = 4'd8;
        end else if (bin >= 6'd30) begin
            tens = 4'd3;
            off  = 4'd14;
        end else if (bin >= 6'd20) begin
            tens = 4'd2;
            off  = 4'd4;
        end else if (bin >= 6'd10) begin
            tens = 4'd1;
            off  = 4'd10;
        end
        // off is (10*tens) mod 16, so the low nibble subtraction yields the units digit
        units = bin[3:0] - off;
    end

endmodule

// File: rtl/alarm_unit_ctrl.sv
// Alarm controller: stores the alarm time, matches it on minute ticks and
// sequences arm / ring / snooze / timeout; alarm time is shown in BCD.
module alarm_unit_ctrl
    import alarm_unit_ctrl_pkg::*;
#(
    parameter int INIT_HOUR        = 6,
    parameter int INIT_MIN         = 30,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int CNT_BITS         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_alarm,
    input  logic       min_inc,
    input  logic       hr_inc,
    input  logic       mode_12h,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    input  logic       minute_tick,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic [3:0] unit_min,
    output logic [3:0] tens_min,
    output logic [3:0] unit_hour,
    output logic [3:0] tens_hour,
    output logic       pm,
    output logic       ringing,
    output logic [1:0] state
);

    logic [4:0]          hour;
    logic [5:0]          min;
    alarm_state_t        state_q, state_d;
    logic [CNT_BITS-1:0] ring_cnt_q, ring_cnt_d;
    logic [CNT_BITS-1:0] snz_cnt_q, snz_cnt_d;
    logic                match;
    logic [4:0]          disp_hour;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hour <= 5'(INIT_HOUR);
            min  <= 6'(INIT_MIN);
        end else if (set_alarm) begin
            if (min_inc)
                min <= (min == 6'(MIN_PER_HOUR - 1)) ? 6'd0 : min + 6'd1;
            if (hr_inc)
                hour <= (hour == 5'(HOURS_PER_DAY - 1)) ? 5'd0 : hour + 5'd1;
        end
    end

    assign match = (cur_hour == hour) && (cur_min == min);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_DISARMED;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
        end
    end

    // Priority: alarm_en low > set_alarm > stop > snooze > minute_tick.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        if (!alarm_en) begin
            state_d = ST_DISARMED;
        end else begin
            case (state_q)
                ST_DISARMED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (!set_alarm && minute_tick && match) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = '0;
                    end
                end
                ST_RINGING: begin
                    if (set_alarm || stop) begin
                        state_d = ST_ARMED;
                    end else if (snooze) begin
                        state_d   = ST_SNOOZING;
                        snz_cnt_d = CNT_BITS'(SNOOZE_MIN);
                    end else if (minute_tick) begin
                        ring_cnt_d = ring_cnt_q + 1'b1;
                        if (ring_cnt_q == CNT_BITS'(RING_TIMEOUT_MIN - 1))
                            state_d = ST_ARMED;
                    end
                end
                ST_SNOOZING: begin
                    if (set_alarm || stop) begin
                        state_d = ST_ARMED;
                    end else if (minute_tick) begin
                        if (snz_cnt_q <= CNT_BITS'(1)) begin
                            snz_cnt_d  = '0;
                            ring_cnt_d = '0;
                            state_d    = ST_RINGING;
                        end else begin
                            snz_cnt_d = snz_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = ST_DISARMED;
            endcase
        end
    end

    assign state   = state_q;
    assign ringing = (state_q == ST_RINGING);

    assign disp_hour = display_hour(hour, mode_12h);
    assign pm        = mode_12h && (hour >= 5'd12);

    bcd_split_2digit u_min_bcd (
        .bin   (min),
        .tens  (tens_min),
        .units (unit_min)
    );

    bcd_split_2digit u_hour_bcd (
        .bin   ({1'b0, disp_hour}),
        .tens  (tens_hour),
        .units (unit_hour)
    );

endmodule
